// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX pipeline register of the 5-stage MIPS core.
// Captures decoder control, register read data, immediate and register
// specifiers each cycle; inserts a bubble on stall or flush and keeps
// stall/flush event counters.
// Ports:
//   clock, reset          - core clock, synchronous active-high reset
//   stall_n, flush        - bubble requests (flush has priority over stall)
//   id_*                  - ID-stage control, data and instruction fields
//   idex_*                - registered copies for the EX stage
//   idex_valid            - 1 = real instruction, 0 = bubble
//   stall_cnt, flush_cnt  - wrapping event counters, CNT_W bits wide
module idex_pipe_reg #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall_n,
  input  logic             flush,
  input  logic             id_RegDst,
  input  logic             id_Branch,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_MemToReg,
  input  logic             id_ALUSrc,
  input  logic             id_RegWrite,
  input  logic [1:0]       id_ALUcntrl,
  input  logic [31:0]      id_pc_plus4,
  input  logic [31:0]      id_rdA,
  input  logic [31:0]      id_rdB,
  input  logic [31:0]      id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_shamt,
  output logic             idex_RegDst,
  output logic             idex_Branch,
  output logic             idex_MemRead,
  output logic             idex_MemWrite,
  output logic             idex_MemToReg,
  output logic             idex_ALUSrc,
  output logic             idex_RegWrite,
  output logic [1:0]       idex_ALUcntrl,
  output logic [31:0]      idex_pc_plus4,
  output logic [31:0]      idex_rdA,
  output logic [31:0]      idex_rdB,
  output logic [31:0]      idex_imm,
  output logic [4:0]       idex_rs,
  output logic [4:0]       idex_rt,
  output logic [4:0]       idex_rd,
  output logic [4:0]       idex_shamt,
  output logic             idex_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Control bits grouped: {RegDst, Branch, MemRead, MemWrite, MemToReg,
  // ALUSrc, RegWrite, ALUcntrl[1:0]}.
  logic [8:0]       ctrl_d, ctrl_q;
  logic             valid_d, valid_q;
  logic [31:0]      pc_plus4_d, pc_plus4_q;
  logic [31:0]      rdA_d, rdA_q;
  logic [31:0]      rdB_d, rdB_q;
  logic [31:0]      imm_d, imm_q;
  logic [4:0]       rs_d, rs_q;
  logic [4:0]       rt_d, rt_q;
  logic [4:0]       rd_d, rd_q;
  logic [4:0]       shamt_d, shamt_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             bubble;

  assign bubble = flush | ~stall_n;

  always_comb begin
    // A bubble zeroes all control so it cannot write registers or memory,
    // but data fields still follow ID so bubble contents are deterministic.
    ctrl_d      = bubble ? 9'd0 :
                  {id_RegDst, id_Branch, id_MemRead, id_MemWrite,
                   id_MemToReg, id_ALUSrc, id_RegWrite, id_ALUcntrl};
    valid_d     = ~bubble;
    pc_plus4_d  = id_pc_plus4;
    rdA_d       = id_rdA;
    rdB_d       = id_rdB;
    imm_d       = id_imm;
    rs_d        = id_rs;
    rt_d        = id_rt;
    rd_d        = id_rd;
    shamt_d     = id_shamt;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    // Flush takes the event even when a stall is requested the same cycle.
    if (flush) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (!stall_n) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q      <= '0;
      valid_q     <= 1'b0;
      pc_plus4_q  <= '0;
      rdA_q       <= '0;
      rdB_q       <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      shamt_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      pc_plus4_q  <= pc_plus4_d;
      rdA_q       <= rdA_d;
      rdB_q       <= rdB_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      shamt_q     <= shamt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign {idex_RegDst, idex_Branch, idex_MemRead, idex_MemWrite,
          idex_MemToReg, idex_ALUSrc, idex_RegWrite, idex_ALUcntrl} = ctrl_q;
  assign idex_valid    = valid_q;
  assign idex_pc_plus4 = pc_plus4_q;
  assign idex_rdA      = rdA_q;
  assign idex_rdB      = rdB_q;
  assign idex_imm      = imm_q;
  assign idex_rs       = rs_q;
  assign idex_rt       = rt_q;
  assign idex_rd       = rd_q;
  assign idex_shamt    = shamt_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule
